prbs7_gen_tx: RTL and testbench

Transmit-side PRBS7 pattern source for the SERDES link tests: emits one 64-bit word per enabled cycle using the same recurrence and bit ordering as the `PRBS7Check` receiver, so a looped-back stream self-synchronises in the checker with zero errors. Masked bit positions carry user data XOR-encoded onto the PRBS, recoverable by the checker's mask path. A single-bit error injector lets the bench and the hardware prove that the checker counts errors.

---
 rtl/prbs7_gen_tx.sv | 131 +++++++++++++
 tb/tb_prbs7_gen_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_gen_tx.sv
// PRBS7 (x^7 + x^6 + 1) transmit source: one contiguous 64-bit word per enabled cycle,
// with XOR-encoded user bits and an optional single-bit error injector (PRBS7_GEN_ERR_INJ_EN).
module prbs7_gen_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        seed_load,
  input  logic [6:0]  seed,
  input  logic [15:0] mask,
  input  logic [15:0] user_pattern,
  input  logic        inj_req,
  input  logic [5:0]  inj_pos,
  output logic [63:0] dout,
  output logic        dout_valid,
  output logic        inj_ack,
  output logic [15:0] inj_count,
  output logic [31:0] word_count
);

  localparam int DATA_W = 64;
  localparam int MASK_W = 16;

  function automatic logic [6:0] seed_fix(input logic [6:0] sd);
    return (sd == 7'd0) ? 7'h7F : sd;
  endfunction

  // x[0..6] is the current state (oldest first); the word is x[7..70].
  function automatic logic [DATA_W-1:0] prbs_word(input logic [6:0] s);
    logic [DATA_W+6:0] x;
    x = '0;
    x[6:0] = s;
    for (int n = 0; n < DATA_W; n++) begin
      x[n+7] = x[n+1] ^ x[n];
    end
    return x[DATA_W+6:7];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [6:0]        r_state;
  logic [DATA_W-1:0] r_dout_p1;
  logic              r_vld_p1;
  logic [31:0]       r_wc_p1;

  logic [DATA_W-1:0] w_prbs;
  logic [DATA_W-1:0] w_user;
  logic [DATA_W-1:0] w_inj_vec;
  logic              w_emit;

  assign w_prbs = prbs_word(r_state);
  assign w_user = {4{mask & user_pattern}};
  assign w_emit = en & ~seed_load;

  // Stage p0 -> p1: PRBS expansion, user/injection XOR and counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= seed_fix(seed);
      r_dout_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_wc_p1   <= '0;
    end else if (seed_load) begin
      r_state  <= seed_fix(seed);
      r_vld_p1 <= 1'b0;
    end else if (en) begin
      r_state   <= w_prbs[DATA_W-1:DATA_W-7];
      r_dout_p1 <= w_prbs ^ w_user ^ w_inj_vec;
      r_vld_p1  <= 1'b1;
      r_wc_p1   <= r_wc_p1 + 32'd1;
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

`ifdef PRBS7_GEN_ERR_INJ_EN
  typedef enum logic {INJ_IDLE, INJ_PEND} inj_state_t;

  inj_state_t        r_inj_state;
  logic [5:0]        r_inj_pos_q;
  logic              r_inj_ack_p1;
  logic [MASK_W-1:0] r_inj_cnt_p1;
  logic              w_inj_fire;

  // A request is only ever applied on an emitting cycle after the one that captured it.
  assign w_inj_fire = (r_inj_state == INJ_PEND) & w_emit;
  assign w_inj_vec  = w_inj_fire ? (64'd1 << r_inj_pos_q) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inj_state  <= INJ_IDLE;
      r_inj_pos_q  <= '0;
      r_inj_ack_p1 <= 1'b0;
      r_inj_cnt_p1 <= '0;
    end else begin
      r_inj_ack_p1 <= 1'b0;
      case (r_inj_state)
        INJ_IDLE: begin
          if (inj_req) begin
            r_inj_pos_q <= inj_pos;
            r_inj_state <= INJ_PEND;
          end
        end
        INJ_PEND: begin
          if (w_inj_fire) begin
            r_inj_ack_p1 <= 1'b1;
            r_inj_cnt_p1 <= sat_inc16(r_inj_cnt_p1);
            r_inj_state  <= INJ_IDLE;
          end
        end
        default: r_inj_state <= INJ_IDLE;
      endcase
    end
  end

  assign inj_ack   = r_inj_ack_p1;
  assign inj_count = r_inj_cnt_p1;
`else
  logic w_unused_inj;

  assign w_unused_inj = ^{inj_req, inj_pos, w_emit, sat_inc16(16'h0)};
  assign w_inj_vec    = '0;
  assign inj_ack      = 1'b0;
  assign inj_count    = 16'h0;
`endif

  assign dout       = r_dout_p1;
  assign dout_valid = r_vld_p1;
  assign word_count = r_wc_p1;

endmodule

// File: tb/tb_prbs7_gen_tx.sv
// Directed bench for prbs7_gen_tx: a bit-serial PRBS7 reference plus literal pins.
module tb_prbs7_gen_tx;
`ifdef PRBS7_GEN_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, seed_load, inj_req;
  logic [6:0]  seed;
  logic [15:0] mask, user_pattern;
  logic [5:0]  inj_pos;
  logic [63:0] dout;
  logic        dout_valid, inj_ack;
  logic [15:0] inj_count;
  logic [31:0] word_count;

  int errors = 0;
  int checks = 0;
  int ack_seen = 0;

  bit          m_win[$];
  logic [63:0] m_dout, m_p, first;
  logic        m_vld, m_ack, m_pend;
  logic [5:0]  m_pos;
  logic [15:0] m_ic;
  logic [31:0] m_wc;

  prbs7_gen_tx dut (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
    .mask(mask), .user_pattern(user_pattern), .inj_req(inj_req), .inj_pos(inj_pos),
    .dout(dout), .dout_valid(dout_valid), .inj_ack(inj_ack),
    .inj_count(inj_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_load(input logic [6:0] sd);
    logic [6:0] v;
    v = (sd == 7'd0) ? 7'h7F : sd;
    m_win.delete();
    for (int i = 0; i < 7; i++) m_win.push_back(v[i]);
  endfunction

  // Serial stream: each new bit is the XOR of the two oldest bits in the window.
  function automatic logic [63:0] m_next_word();
    logic [63:0] w;
    bit b;
    for (int i = 0; i < 64; i++) begin
      b = m_win[0] ^ m_win[1];
      m_win.push_back(b);
      void'(m_win.pop_front());
      w[i] = b;
    end
    return w;
  endfunction

  function automatic void model_step();
    logic [63:0] inj;
    logic was_pend;
    was_pend = m_pend;
    if (!reset) begin
      m_load(seed);
      m_dout = '0; m_vld = 0; m_ack = 0; m_ic = '0; m_wc = '0; m_pend = 0;
    end else begin
      m_ack = 0;
      if (seed_load) begin
        m_load(seed);
        m_vld = 0;
      end else if (en) begin
        m_p = m_next_word();
        inj = '0;
        if (INJ && was_pend) begin
          inj = 64'd1 << m_pos;
          m_ack = 1;
          if (m_ic != 16'hFFFF) m_ic = m_ic + 16'd1;
          m_pend = 0;
        end
        m_dout = m_p ^ {4{mask & user_pattern}} ^ inj;
        m_vld = 1;
        m_wc = m_wc + 32'd1;
      end else begin
        m_vld = 0;
      end
      if (INJ && !was_pend && inj_req) begin
        m_pend = 1;
        m_pos = inj_pos;
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("dout", dout, m_dout);
      chk("dout_valid", {63'd0, dout_valid}, {63'd0, m_vld});
      chk("inj_ack", {63'd0, inj_ack}, {63'd0, m_ack});
      chk("inj_count", {48'd0, inj_count}, {48'd0, m_ic});
      chk("word_count", {32'd0, word_count}, {32'd0, m_wc});
      if (inj_ack === 1'b1) ack_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 0; en = 0; seed_load = 0; seed = 7'h7F; mask = '0; user_pattern = '0;
    inj_req = 0; inj_pos = '0;
    cyc(3);
    chk("rst_dout", dout, 64'd0);
    chk("rst_wc", {32'd0, word_count}, 64'd0);
    chk("rst_vld", {63'd0, dout_valid}, 64'd0);

    reset = 1; en = 1;
    cyc(1);
    chk("first_byte", {56'd0, dout[7:0]}, 64'h40);
    chk("first_bit12", {63'd0, dout[12]}, 64'd1);
    first = m_dout;
    cyc(126);
    cyc(1);
    chk("period_127", dout, first);

    en = 0;
    cyc(3);
    chk("idle_vld", {63'd0, dout_valid}, 64'd0);
    chk("idle_wc", {32'd0, word_count}, 64'd128);

    seed = 7'd0; seed_load = 1; en = 1;
    cyc(1);
    chk("load_vld", {63'd0, dout_valid}, 64'd0);
    chk("load_wc", {32'd0, word_count}, 64'd128);
    seed_load = 0;
    cyc(1);
    chk("zero_seed_first", dout, first);
    cyc(4);

    seed = 7'h01; seed_load = 1;
    cyc(1);
    seed_load = 0;
    cyc(5);

    mask = 16'h0080; user_pattern = 16'h0080;
    repeat (20) begin
      cyc(1);
      chk("user_bits", dout ^ m_p, 64'h0080008000800080);
    end
    mask = 16'h1234; user_pattern = 16'hFFFF;
    cyc(4);
    mask = '0; user_pattern = '0;

    ack_seen = 0;
    inj_req = 1; inj_pos = 6'd37;
    cyc(1);
    inj_req = 0;
    cyc(4);
    chk("inj37_acks", ack_seen, INJ ? 64'd1 : 64'd0);
    chk("inj37_count", {48'd0, inj_count}, INJ ? 64'd1 : 64'd0);

    en = 0; inj_req = 1; inj_pos = 6'd5;
    cyc(1);
    inj_pos = 6'd9;
    cyc(1);
    inj_req = 0; en = 1;
    cyc(3);
    chk("double_req_count", {48'd0, inj_count}, INJ ? 64'd2 : 64'd0);

    en = 0; inj_req = 1; inj_pos = 6'd20;
    cyc(1);
    inj_req = 0; reset = 0;
    cyc(1);
    reset = 1; en = 1; ack_seen = 0;
    cyc(5);
    chk("rst_pend_acks", ack_seen, 64'd0);

    reset = 0;
    cyc(1);
    reset = 1;
    cyc(3);
    chk("midrst_wc", {32'd0, word_count}, 64'd3);

    force dut.r_wc_p1 = 32'hFFFF_FFFF;
    m_wc = 32'hFFFF_FFFF;
    #1 release dut.r_wc_p1;
    cyc(1);
    chk("wc_wrap", {32'd0, word_count}, 64'd0);
    cyc(1);
    chk("wc_after_wrap", {32'd0, word_count}, 64'd1);

`ifdef PRBS7_GEN_ERR_INJ_EN
    force dut.r_inj_cnt_p1 = 16'hFFFE;
    m_ic = 16'hFFFE;
    #1 release dut.r_inj_cnt_p1;
    cyc(1);
    repeat (3) begin
      inj_req = 1; inj_pos = 6'd63;
      cyc(1);
      inj_req = 0;
      cyc(1);
    end
    chk("inj_sat", {48'd0, inj_count}, 64'hFFFF);
`endif

    en = 0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
